// File: rtl/csa14_accumulator_pkg.sv
// Shared definitions for the carry-select accumulator: FSM encoding and default datapath width.
package csa14_accumulator_pkg;

    localparam int DEF_WIDTH = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/csa_14bit.sv
// 14-bit carry-select adder: the low half ripples, the high half is precomputed
// for both possible carries and selected by the low-half carry-out.
module csa_14bit
    import csa14_accumulator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic [LO_W:0] w_lo;
    logic [HI_W:0] w_hi0;
    logic [HI_W:0] w_hi1;
    logic [HI_W:0] w_hi;

    assign w_lo  = {1'b0, i_a[LO_W-1:0]} + {1'b0, i_b[LO_W-1:0]} + {{LO_W{1'b0}}, i_cin};
    assign w_hi0 = {1'b0, i_a[WIDTH-1:LO_W]} + {1'b0, i_b[WIDTH-1:LO_W]};
    assign w_hi1 = {1'b0, i_a[WIDTH-1:LO_W]} + {1'b0, i_b[WIDTH-1:LO_W]} + {{HI_W{1'b0}}, 1'b1};
    assign w_hi  = w_lo[LO_W] ? w_hi1 : w_hi0;

    assign o_sum  = {w_hi[HI_W-1:0], w_lo[LO_W-1:0]};
    assign o_cout = w_hi[HI_W];

endmodule

// File: rtl/csa14_accumulator.sv
// Beat accumulator with valid/ready in and out; sums beats up to i_last, then holds the
// result (sum, sticky carry, saturating beat count) until downstream takes it.
module csa14_accumulator
    import csa14_accumulator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    input  logic             i_clear,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_count
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_flush;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [CNT_W-1:0] w_count_inc;

    // The accumulator is always zero in IDLE, so one adder path serves both the first and later beats.
    csa_14bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (r_acc),
        .i_b    (i_data),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_flush     = 1'b0;
        o_ready     = 1'b0;
        if (i_clear) begin
            w_state_nxt = ST_IDLE;
            w_flush     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACC: begin
                    o_ready = 1'b1;
                    if (i_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = i_last ? ST_DONE : ST_ACC;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        w_flush     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_flush) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= w_sum;
            r_ovf   <= r_ovf | w_cout;
            r_count <= w_count_inc;
        end
    end

    assign o_valid = (r_state == ST_DONE);
    assign o_acc   = r_acc;
    assign o_ovf   = r_ovf;
    assign o_count = r_count;

endmodule

// File: tb/tb_csa14_accumulator.sv
// Directed bench for csa14_accumulator: a per-cycle vector table plus hand sequences
// for counter saturation and an asynchronous mid-sum reset.
module tb_csa14_accumulator;

    localparam int W  = 14;
    localparam int CW = 8;
    localparam int NV = 34;

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic          l;
        logic          c;
        logic          r;
        logic          e_rdy;
        logic          e_vld;
        logic [W-1:0]  e_acc;
        logic          e_ovf;
        logic [CW-1:0] e_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic          ready_out;
    logic [W-1:0]  data_in;
    logic          last_in;
    logic          clear_in;
    logic          valid_out;
    logic          ready_in;
    logic [W-1:0]  acc_out;
    logic          ovf_out;
    logic [CW-1:0] count_out;

    int errors = 0;
    int checks = 0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    csa14_accumulator #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .i_data  (data_in),
        .i_last  (last_in),
        .i_clear (clear_in),
        .o_valid (valid_out),
        .i_ready (ready_in),
        .o_acc   (acc_out),
        .o_ovf   (ovf_out),
        .o_count (count_out)
    );

    function automatic vec_t mk(input logic v, input int d, input logic l, input logic c,
                                input logic r, input logic e_rdy, input logic e_vld,
                                input int e_acc, input logic e_ovf, input int e_cnt);
        vec_t x;
        x.v = v; x.d = W'(d); x.l = l; x.c = c; x.r = r;
        x.e_rdy = e_rdy; x.e_vld = e_vld; x.e_acc = W'(e_acc); x.e_ovf = e_ovf; x.e_cnt = CW'(e_cnt);
        return x;
    endfunction

    // Compares {ready, valid, acc, ovf, count} against the required tuple.
    task automatic check_out(input string name, input logic e_rdy, input logic e_vld,
                             input logic [W-1:0] e_acc, input logic e_ovf, input logic [CW-1:0] e_cnt);
        checks++;
        if (ready_out !== e_rdy || valid_out !== e_vld || acc_out !== e_acc ||
            ovf_out !== e_ovf || count_out !== e_cnt) begin
            errors++;
            $display("FAIL %s: got rdy=%b vld=%b acc=%0d ovf=%b cnt=%0d, want rdy=%b vld=%b acc=%0d ovf=%b cnt=%0d",
                     name, ready_out, valid_out, acc_out, ovf_out, count_out,
                     e_rdy, e_vld, e_acc, e_ovf, e_cnt);
        end
    endtask

    task automatic drive(input logic v, input int d, input logic l, input logic c, input logic r);
        valid_in = v; data_in = W'(d); last_in = l; clear_in = c; ready_in = r;
    endtask

    initial begin
        // Columns: v, d, l, clear, i_ready | exp ready, valid, acc, ovf, count (seen before the edge)
        vecs[0]  = mk(1, 100,   0, 0, 0,  1, 0, 0,     0, 0);
        vecs[1]  = mk(1, 200,   0, 0, 0,  1, 0, 100,   0, 1);
        vecs[2]  = mk(1, 300,   1, 0, 0,  1, 0, 300,   0, 2);
        vecs[3]  = mk(0, 0,     0, 0, 1,  0, 1, 600,   0, 3);
        vecs[4]  = mk(0, 0,     0, 0, 0,  1, 0, 0,     0, 0);
        vecs[5]  = mk(1, 16383, 0, 0, 0,  1, 0, 0,     0, 0);
        vecs[6]  = mk(1, 1,     1, 0, 0,  1, 0, 16383, 0, 1);
        vecs[7]  = mk(0, 0,     0, 0, 1,  0, 1, 0,     1, 2);
        vecs[8]  = mk(0, 0,     0, 0, 0,  1, 0, 0,     0, 0);
        vecs[9]  = mk(1, 5,     1, 0, 0,  1, 0, 0,     0, 0);
        vecs[10] = mk(0, 0,     0, 0, 0,  0, 1, 5,     0, 1);
        vecs[11] = mk(0, 0,     0, 0, 0,  0, 1, 5,     0, 1);
        vecs[12] = mk(1, 7,     0, 0, 0,  0, 1, 5,     0, 1);
        vecs[13] = mk(0, 0,     0, 0, 0,  0, 1, 5,     0, 1);
        vecs[14] = mk(0, 0,     0, 0, 0,  0, 1, 5,     0, 1);
        vecs[15] = mk(0, 0,     0, 0, 1,  0, 1, 5,     0, 1);
        vecs[16] = mk(1, 9,     1, 0, 0,  1, 0, 0,     0, 0);
        vecs[17] = mk(0, 0,     0, 0, 1,  0, 1, 9,     0, 1);
        vecs[18] = mk(0, 0,     0, 0, 0,  1, 0, 0,     0, 0);
        vecs[19] = mk(1, 10,    0, 0, 0,  1, 0, 0,     0, 0);
        vecs[20] = mk(1, 20,    0, 0, 0,  1, 0, 10,    0, 1);
        vecs[21] = mk(1, 30,    0, 1, 0,  0, 0, 30,    0, 2);
        vecs[22] = mk(1, 4,     1, 0, 0,  1, 0, 0,     0, 0);
        vecs[23] = mk(0, 0,     0, 0, 1,  0, 1, 4,     0, 1);
        vecs[24] = mk(0, 0,     0, 0, 0,  1, 0, 0,     0, 0);
        vecs[25] = mk(1, 3,     0, 0, 0,  1, 0, 0,     0, 0);
        vecs[26] = mk(0, 0,     0, 0, 0,  1, 0, 3,     0, 1);
        vecs[27] = mk(0, 0,     0, 0, 0,  1, 0, 3,     0, 1);
        vecs[28] = mk(1, 2,     1, 0, 0,  1, 0, 3,     0, 1);
        vecs[29] = mk(0, 0,     0, 0, 1,  0, 1, 5,     0, 2);
        vecs[30] = mk(0, 0,     0, 0, 0,  1, 0, 0,     0, 0);
        vecs[31] = mk(1, 1,     1, 0, 0,  1, 0, 0,     0, 0);
        vecs[32] = mk(0, 0,     0, 1, 0,  0, 1, 1,     0, 1);
        vecs[33] = mk(0, 0,     0, 0, 0,  1, 0, 0,     0, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", 1, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_out("ready_after_reset", 1, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].v, int'(vecs[i].d), vecs[i].l, vecs[i].c, vecs[i].r);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vld,
                      vecs[i].e_acc, vecs[i].e_ovf, vecs[i].e_cnt);
        end

        // 300 zero beats: count must saturate at 255
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            drive(1, 0, (k == 299), 0, 0);
            if (k == 255) begin
                #1;
                check_out("sat_reached", 1, 0, 0, 0, 255);
            end
            if (k == 299) begin
                #1;
                check_out("sat_held", 1, 0, 0, 0, 255);
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 1);
        #1;
        check_out("sat_done", 0, 1, 0, 0, 255);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        check_out("sat_idle", 1, 0, 0, 0, 0);

        // Asynchronous reset pulse between edges in the middle of a sum
        @(negedge clk);
        drive(1, 7, 0, 0, 0);
        @(negedge clk);
        drive(1, 8, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        check_out("pre_reset_partial", 1, 0, 15, 0, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check_out("async_reset_zero", 1, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check_out($sformatf("no_valid_after_abort%0d", k), 1, 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(1, 2, 1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1);
        #1;
        check_out("fresh_sum_after_reset", 0, 1, 2, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csa14_accumulator.md
CSA14_ACCUMULATOR -- requirements
Module: csa14_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 14, giving the operand and accumulator width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, giving the beat-counter width in bits.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset input exists.
REQ-004 i_clk  input  1  clock; all state changes on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_valid  input  1  upstream beat valid.
REQ-007 o_ready  output  1  block can accept a beat this cycle.
REQ-008 i_data  input  WIDTH  operand to add into the accumulator.
REQ-009 i_last  input  1  qualifies the accepted beat as the final term of the sum.
REQ-010 i_clear  input  1  synchronous abort-and-clear.
REQ-011 o_valid  output  1  result valid to downstream.
REQ-012 i_ready  input  1  downstream accepts the result.
REQ-013 o_acc  output  WIDTH  accumulated sum, modulo 2^WIDTH.
REQ-014 o_ovf  output  1  sticky carry-out of any addition in the current sum.
REQ-015 o_count  output  CNT_W  number of beats accumulated, saturating.

Function
REQ-016 A beat is accepted when i_valid=1 and o_ready=1 on the same rising edge.
REQ-017 o_ready SHALL be 1 in IDLE and ACC, and 0 in DONE; it SHALL also be 0 in any cycle with i_clear=1.
REQ-018 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-019 Accept in IDLE: acc<=0+i_data, count<=1, ovf<=cout; next state is DONE if i_last=1, else ACC.
REQ-020 Accept in ACC: acc<=acc+i_data, count<=count+1 saturating at 2^CNT_W-1, ovf<=ovf|cout; next state is DONE if i_last=1, else ACC.
REQ-021 Each addition SHALL complete combinationally in a single cycle with carry-in 0; sum bits above WIDTH are dropped, and the carry-out only feeds ovf.
REQ-022 DONE: o_valid=1; o_acc, o_ovf and o_count hold stable; i_valid, i_data and i_last are ignored.
REQ-023 DONE with i_ready=1: next state IDLE with acc, count and ovf cleared; no beat is accepted in that cycle.
REQ-024 Latency: o_valid SHALL rise on the first cycle after the edge that accepted the i_last beat.
REQ-025 o_valid SHALL be 0 in IDLE and ACC; o_acc, o_ovf and o_count SHALL show the running values in those states.
REQ-026 i_clear=1 has top priority in any state: next state IDLE, acc, count and ovf cleared, o_valid dropped, and any simultaneous beat or i_ready ignored.
REQ-027 No beat is presented while in ACC: the state and all registers hold.

Reset
REQ-028 Reset assertion SHALL take effect asynchronously: state IDLE, acc=0, count=0, ovf=0, o_valid=0.
REQ-029 Reset assertion mid-sum SHALL discard the partial result, and no o_valid pulse SHALL follow.
REQ-030 After reset deassertion, o_ready=1 on the first clock edge.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration (IDLE/ACC/DONE) and the WIDTH=14 default constant.
REQ-032 The adder SHALL be a single instance of the team's existing 14-bit carry-select adder (csa_14bit), with the accumulator register on operand 1, i_data on operand 2, and its sum and cout feeding the registers.
REQ-033 The block SHALL contain no other arithmetic sub-module; the counter increment is a local saturating adder.

Verification
REQ-034 Beats 100, 200, 300 (last on 300), i_ready=1 -> o_valid for 1 cycle, o_acc=600, o_count=3, o_ovf=0.
REQ-035 Beats 16383, 1 (last) -> o_acc=0, o_ovf=1, o_count=2.
REQ-036 Single beat 5 with i_last, i_ready held 0 for 5 cycles -> o_valid=1 and o_acc=5 for all 5 cycles, o_ready=0; an i_valid beat of 7 in that window is not absorbed; after i_ready=1 the next sum starts from 0.
REQ-037 Beats 10, 20, then i_clear with i_valid=1 and data 30 -> IDLE, o_acc=0, o_count=0; next beat 4 (last) -> o_acc=4.
REQ-038 300 beats of 0, last on the 300th -> o_count=255, o_acc=0.
REQ-039 i_rst_n pulsed low between clock edges mid-sum -> outputs zero immediately, o_valid never asserts for the aborted sum.
